traffic_input_cond: RTL and testbench

- Upstream conditioning stage for the traffic-light controller FSM.
- Produces the single-cycle 1 s timebase enable that the controller's countdown consumes, replacing a divided clock with a clock-enable.
- Debounces the raw pedestrian pushbutton and holds the request until the controller acknowledges it.
- Keeps a saturating count of accepted requests for display.

---
 rtl/traffic_input_cond_if.sv | 36 +++
 rtl/traffic_input_cond.sv | 139 +++++++++++++
 tb/tb_traffic_input_cond.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/traffic_input_cond_if.sv
// Bus between the traffic-light input conditioning stage and its controller.
//   key_n     : raw active-low pushbutton (into the conditioner)
//   ack       : single-cycle acknowledge from the controller, clears ped_req
//   tick      : one-cycle 1 s timebase enable
//   key_level : debounced button level, 1 = pressed
//   ped_req   : latched pedestrian request
//   req_count : saturating count of accepted presses
// The slave modport is the conditioner, the master modport is the controller side.
interface traffic_input_cond_if #(
  parameter int unsigned CNT_W = 8
);
  logic             key_n;
  logic             ack;
  logic             tick;
  logic             key_level;
  logic             ped_req;
  logic [CNT_W-1:0] req_count;

  modport master (
    output key_n,
    output ack,
    input  tick,
    input  key_level,
    input  ped_req,
    input  req_count
  );

  modport slave (
    input  key_n,
    input  ack,
    output tick,
    output key_level,
    output ped_req,
    output req_count
  );
endinterface

// File: rtl/traffic_input_cond.sv
// Upstream conditioning stage for the traffic-light controller.
// Generates a one-cycle timebase enable every TICK_DIV clocks, debounces the
// asynchronous pedestrian pushbutton, latches the request until the
// controller acknowledges it, and counts accepted presses (saturating).
// Ports:
//   CLOCK_50 : system clock, all state updates on its rising edge
//   rst      : synchronous active-high reset
//   bus      : traffic_input_cond_if.slave (key_n, ack in; tick, key_level,
//              ped_req, req_count out)
module traffic_input_cond #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 rst,
  traffic_input_cond_if.slave  bus
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_e;

  db_state_e        state_q, state_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             key_level_q, key_level_d;
  logic             ped_req_q, ped_req_d;
  logic [CNT_W-1:0] req_count_q, req_count_d;

  logic             s;
  logic             press;

  // Synchronized, active-high view of the button.
  assign s = ~sync2_q;

  // Divider and synchronizer next state. tick is registered from div_d so it
  // is high exactly while div_q sits at its last value.
  always_comb begin
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d  = (div_d == DIV_LAST);
    sync1_d = bus.key_n;
    sync2_d = sync1_q;
  end

  // Debounce state register.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q  <= RELEASED;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Debounce next state. The counter defaults to zero so every state entry,
  // and every cycle spent in a stable state, starts a fresh window.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = '0;
    case (state_q)
      RELEASED: begin
        if (s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!s)                      state_d = RELEASED;
        else if (db_cnt_q == DB_LAST) state_d = PRESSED;
        else                         db_cnt_d = db_cnt_q + DB_W'(1);
      end
      PRESSED: begin
        if (!s) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (s)                        state_d = PRESSED;
        else if (db_cnt_q == DB_LAST) state_d = RELEASED;
        else                          db_cnt_d = db_cnt_q + DB_W'(1);
      end
      default: state_d = RELEASED;
    endcase
  end

  // Debounce outputs. Only an accepted press produces an event; key_level is
  // registered from the next state so it follows the state register exactly.
  always_comb begin
    press       = (state_q == PRESS_WAIT) && (state_d == PRESSED);
    key_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  // Request latch and press counter. A new press wins over a same-cycle ack.
  always_comb begin
    ped_req_d   = ped_req_q;
    req_count_d = req_count_q;
    if (press)        ped_req_d = 1'b1;
    else if (bus.ack) ped_req_d = 1'b0;
    if (press && (req_count_q != CNT_MAX)) req_count_d = req_count_q + CNT_W'(1);
  end

  // Datapath registers. Synchronizer flops reset to the released level.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      div_q       <= '0;
      tick_q      <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      key_level_q <= 1'b0;
      ped_req_q   <= 1'b0;
      req_count_q <= '0;
    end else begin
      div_q       <= div_d;
      tick_q      <= tick_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      key_level_q <= key_level_d;
      ped_req_q   <= ped_req_d;
      req_count_q <= req_count_d;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.key_level = key_level_q;
  assign bus.ped_req   = ped_req_q;
  assign bus.req_count = req_count_q;

endmodule

// File: tb/tb_traffic_input_cond.sv
// Testbench for traffic_input_cond with TICK_DIV=10, DB_CYCLES=4, CNT_W=3.
// Directed table segments and corner-case sequences, followed by random
// stimulus, all cross-checked every cycle against a behavioural model.
module tb_traffic_input_cond;

  localparam int TICK_DIV  = 10;
  localparam int DB_CYCLES = 4;
  localparam int CNT_W     = 3;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  traffic_input_cond_if #(.CNT_W(CNT_W)) bus ();

  traffic_input_cond #(
    .TICK_DIV (TICK_DIV),
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) dut (
    .CLOCK_50(clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the button history is a two-deep delay line, the
  // debounced level flips once the synchronized input has disagreed with it
  // for DB_CYCLES+1 consecutive samples, and the timebase is a plain count
  // of cycles since reset.
  bit mSync1  = 1'b1;
  bit mSync2  = 1'b1;
  bit mLevel  = 1'b0;
  bit mReq    = 1'b0;
  bit mTick   = 1'b0;
  int mRun    = 0;
  int mCount  = 0;
  int mEdges  = 0;

  typedef struct {
    bit    rst;
    bit    keyN;
    bit    ack;
    int    cycles;
    bit    expLevel;
    bit    expReq;
    int    expCount;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of the reference model, using the inputs the DUT will sample.
  task automatic modelStep(input bit r, input bit k, input bit a);
    bit s;
    bit press;
    if (r) begin
      mSync1 = 1'b1;
      mSync2 = 1'b1;
      mLevel = 1'b0;
      mReq   = 1'b0;
      mTick  = 1'b0;
      mRun   = 0;
      mCount = 0;
      mEdges = 0;
    end else begin
      s     = ~mSync2;
      press = 1'b0;
      if (s != mLevel) begin
        mRun++;
        if (mRun == DB_CYCLES + 1) begin
          mLevel = s;
          mRun   = 0;
          press  = s;
        end
      end else begin
        mRun = 0;
      end
      if (press)  mReq = 1'b1;
      else if (a) mReq = 1'b0;
      if (press && mCount < CNT_MAX) mCount++;
      mSync2 = mSync1;
      mSync1 = k;
      mEdges++;
      mTick = ((mEdges % TICK_DIV) == TICK_DIV - 1);
    end
  endtask

  // Drive inputs at a falling edge, then step through the given number of
  // clocks, comparing the DUT against the model after each rising edge.
  task automatic applyStimulus(input bit r, input bit k, input bit a, input int cycles);
    rst       = r;
    bus.key_n = k;
    bus.ack   = a;
    for (int c = 0; c < cycles; c++) begin
      modelStep(r, k, a);
      @(negedge clk);
      checkOutput("model_tick", 32'(bus.tick), 32'(mTick));
      checkOutput("model_key_level", 32'(bus.key_level), 32'(mLevel));
      checkOutput("model_ped_req", 32'(bus.ped_req), 32'(mReq));
      checkOutput("model_req_count", 32'(bus.req_count), 32'(mCount));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int simCycles;
    bit expTick;
    bit key;
    int runLen;

    bus.key_n = 1'b1;
    bus.ack   = 1'b0;

    // Timebase: three reset cycles, then a reset at cycle 45 restarts the period.
    applyStimulus(1'b1, 1'b1, 1'b0, 3);
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(k == 45, 1'b1, 1'b0, 1);
      expTick = (k == 9) || (k == 19) || (k == 29) || (k == 39) || (k == 54);
      checkOutput("tick_timing", 32'(bus.tick), 32'(expTick));
    end

    // Press, release and ack handshake segments.
    vecs.push_back('{1'b1, 1'b1, 1'b0,  2, 1'b0, 1'b0, 0, "reset"});
    vecs.push_back('{1'b0, 1'b0, 1'b0,  6, 1'b0, 1'b0, 0, "press_pending"});
    vecs.push_back('{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1, "press_level"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 13, 1'b1, 1'b1, 1, "press_hold"});
    vecs.push_back('{1'b0, 1'b1, 1'b0,  6, 1'b1, 1'b1, 1, "release_pending"});
    vecs.push_back('{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1, "release_level"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 13, 1'b0, 1'b1, 1, "release_hold"});
    vecs.push_back('{1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b0, 1, "ack_clear"});
    vecs.push_back('{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1, "ack_gap"});
    vecs.push_back('{1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b0, 1, "ack_idle"});
    vecs.push_back('{1'b0, 1'b0, 1'b0,  6, 1'b0, 1'b0, 1, "press2_pending"});
    vecs.push_back('{1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b1, 2, "press_ack_same"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 2, "release2"});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].keyN, vecs[i].ack, vecs[i].cycles);
      checkOutput({vecs[i].name, "_key_level"}, 32'(bus.key_level), 32'(vecs[i].expLevel));
      checkOutput({vecs[i].name, "_ped_req"}, 32'(bus.ped_req), 32'(vecs[i].expReq));
      checkOutput({vecs[i].name, "_req_count"}, 32'(bus.req_count), 32'(vecs[i].expCount));
    end

    // Bounce rejection: toggling every two cycles never qualifies.
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, ((i / 2) % 2) == 1, 1'b0, 1);
      checkOutput("bounce_key_level", 32'(bus.key_level), 32'd0);
      checkOutput("bounce_ped_req", 32'(bus.ped_req), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 10);
    checkOutput("bounce_req_count", 32'(bus.req_count), 32'd0);

    // Saturation: nine presses, count holds at its maximum.
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 10);
      checkOutput("sat_req_count", 32'(bus.req_count), 32'((i < CNT_MAX) ? i : CNT_MAX));
      checkOutput("sat_ped_req", 32'(bus.ped_req), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 10);
      checkOutput("sat_release_level", 32'(bus.key_level), 32'd0);
    end

    // Reset in the middle of a debounce window restarts the full latency.
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("middb_reset_level", 32'(bus.key_level), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6);
    checkOutput("middb_pending_level", 32'(bus.key_level), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("middb_key_level", 32'(bus.key_level), 32'd1);
    checkOutput("middb_req_count", 32'(bus.req_count), 32'd1);

    // Random runs of button levels, sparse acks and rare resets.
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    simCycles = 0;
    while (simCycles < 3000) begin
      runLen = $urandom_range(1, 12);
      key    = $urandom_range(0, 1) == 1;
      for (int j = 0; j < runLen; j++) begin
        applyStimulus($urandom_range(0, 399) == 0, key, $urandom_range(0, 7) == 0, 1);
        simCycles++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
